tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4_if.sv | 23 ++
 rtl/tdm_demux4.sv | 110 +++++++++++
 tb/tb_tdm_demux4.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - serial TDM input and demultiplexed frame output bundle
interface tdm_demux4_if #(
   parameter int W = 8
);
   logic           en;
   logic           din;
   logic           fsync;
   logic [4*W-1:0] D;
   logic [1:0]     S;
   logic           frame_valid;
   logic           locked;
   logic           sync_err;

   modport master (
      output en, din, fsync,
      input  D, S, frame_valid, locked, sync_err
   );

   modport slave (
      input  en, din, fsync,
      output D, S, frame_valid, locked, sync_err
   );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM frame demultiplexer with fsync lock tracking
module tdm_demux4 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   tdm_demux4_if.slave  bus
);
   localparam int BW = (W > 1) ? $clog2(W) : 1;
   // Position reached after storing slot 0 bit 0; with one bit per slot the slot advances immediately.
   localparam logic [BW-1:0] FIRST_BIT  = (W == 1) ? BW'(0) : BW'(1);
   localparam logic [1:0]    FIRST_SLOT = (W == 1) ? 2'd1 : 2'd0;

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t         state_q, state_d;
   logic [BW-1:0]  bit_q, bit_d;
   logic [1:0]     slot_q, slot_d;
   logic [4*W-1:0] asm_q, asm_d;
   logic [4*W-1:0] frame_q;
   logic           fv_q, err_q;
   logic           load, err;
   logic           at_start, at_last;

   assign at_start = (slot_q == 2'd0) && (bit_q == BW'(0));
   assign at_last  = (slot_q == 2'd3) && (bit_q == BW'(W-1));

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      slot_d  = slot_q;
      asm_d   = asm_q;
      load    = 1'b0;
      err     = 1'b0;
      if (bus.en) begin
         case (state_q)
            HUNT: begin
               if (bus.fsync) begin
                  asm_d        = '0;
                  asm_d[W-1]   = bus.din;
                  bit_d        = FIRST_BIT;
                  slot_d       = FIRST_SLOT;
                  state_d      = LOCKED;
               end
            end
            LOCKED: begin
               if (at_start && !bus.fsync) begin
                  err     = 1'b1;
                  state_d = HUNT;
                  asm_d   = '0;
                  bit_d   = '0;
                  slot_d  = '0;
               end else if (!at_start && bus.fsync) begin
                  // Early fsync: drop the partial frame and restart on this bit.
                  err        = 1'b1;
                  asm_d      = '0;
                  asm_d[W-1] = bus.din;
                  bit_d      = FIRST_BIT;
                  slot_d     = FIRST_SLOT;
               end else begin
                  for (int s = 0; s < 4; s++) begin
                     for (int b = 0; b < W; b++) begin
                        if (slot_q == 2'(s) && bit_q == BW'(b))
                           asm_d[s*W + W-1-b] = bus.din;
                     end
                  end
                  if (at_last) begin
                     load   = 1'b1;
                     bit_d  = '0;
                     slot_d = '0;
                  end else if (bit_q == BW'(W-1)) begin
                     bit_d  = '0;
                     slot_d = slot_q + 2'd1;
                  end else begin
                     bit_d  = bit_q + BW'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= HUNT;
         bit_q   <= '0;
         slot_q  <= '0;
         asm_q   <= '0;
         frame_q <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         slot_q  <= slot_d;
         asm_q   <= asm_d;
         if (load)
            frame_q <= asm_d;
         fv_q    <= load;
         err_q   <= err;
      end
   end

   assign bus.D           = frame_q;
   assign bus.locked      = (state_q == LOCKED);
   assign bus.S           = (state_q == LOCKED) ? slot_q : 2'd0;
   assign bus.frame_valid = fv_q;
   assign bus.sync_err    = err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed-vector bench for tdm_demux4 at W=8
module tb_tdm_demux4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tdm_demux4_if #(.W(W)) bus ();
   tdm_demux4 #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;
   int fv_total = 0;
   int err_total = 0;
   int both_total = 0;
   int fv0, er0;

   always @(negedge clk) begin
      if (bus.frame_valid === 1'b1) fv_total++;
      if (bus.sync_err === 1'b1) err_total++;
      if (bus.frame_valid === 1'b1 && bus.sync_err === 1'b1) both_total++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick(input logic e, input logic d, input logic f);
      @(negedge clk);
      bus.en = e;
      bus.din = d;
      bus.fsync = f;
      @(posedge clk);
      #1;
   endtask

   // Flat bit k of a frame: slot k/8, MSB first; fsync rides on k==0. Idle gap cycles carry fsync=1 with en=0.
   task automatic send_bits(input logic [31:0] fr, input int first, input int last, input int gap);
      logic [31:0] sh;
      for (int k = first; k <= last; k++) begin
         repeat (gap) tick(1'b0, 1'b0, 1'b1);
         sh = fr >> ((k / 8) * 8 + 7 - (k % 8));
         tick(1'b1, sh[0], k == 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.en = 1'b0;
      bus.din = 1'b0;
      bus.fsync = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick(1'b0, 1'b0, 1'b0);
      chk("rst_d", bus.D, 32'h0);
      chk("rst_s", 32'(bus.S), 32'd0);
      chk("rst_locked", 32'(bus.locked), 32'd0);
      chk("rst_fv", 32'(bus.frame_valid), 32'd0);
      chk("rst_err", 32'(bus.sync_err), 32'd0);
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 31; i++) begin
         send_bits(32'h01FF3CA5, i, i, 0);
         chk("f1_s", 32'(bus.S), 32'((i + 1) / 8));
         chk("f1_fv", 32'(bus.frame_valid), 32'd0);
      end
      send_bits(32'h01FF3CA5, 31, 31, 0);
      chk("f1_d", bus.D, 32'h01FF3CA5);
      chk("f1_fv_pulse", 32'(bus.frame_valid), 32'd1);
      chk("f1_locked", 32'(bus.locked), 32'd1);
      chk("f1_s_wrap", 32'(bus.S), 32'd0);
      tick(1'b0, 1'b0, 1'b0);
      chk("f1_fv_drop", 32'(bus.frame_valid), 32'd0);
      chk("f1_d_hold", bus.D, 32'h01FF3CA5);

      fv0 = fv_total;
      er0 = err_total;
      send_bits(32'h11223344, 0, 31, 1);
      chk("b2b_d1", bus.D, 32'h11223344);
      chk("b2b_fv1", 32'(bus.frame_valid), 32'd1);
      send_bits(32'hDEADBEEF, 0, 31, 1);
      chk("b2b_d2", bus.D, 32'hDEADBEEF);
      tick(1'b0, 1'b0, 1'b0);
      chk("b2b_fv_count", 32'(fv_total - fv0), 32'd2);
      chk("b2b_err_count", 32'(err_total - er0), 32'd0);

      fv0 = fv_total;
      er0 = err_total;
      send_bits(32'hAAAAAAAA, 0, 18, 0);
      chk("rs_locked_pre", 32'(bus.locked), 32'd1);
      chk("rs_s_pre", 32'(bus.S), 32'd2);
      send_bits(32'h0F0F0F0F, 0, 0, 0);
      chk("rs_err", 32'(bus.sync_err), 32'd1);
      chk("rs_d_hold", bus.D, 32'hDEADBEEF);
      chk("rs_locked", 32'(bus.locked), 32'd1);
      send_bits(32'h0F0F0F0F, 1, 31, 0);
      chk("rs_d", bus.D, 32'h0F0F0F0F);
      chk("rs_fv", 32'(bus.frame_valid), 32'd1);
      chk("rs_locked_post", 32'(bus.locked), 32'd1);
      tick(1'b0, 1'b0, 1'b0);
      chk("rs_fv_count", 32'(fv_total - fv0), 32'd1);
      chk("rs_err_count", 32'(err_total - er0), 32'd1);

      fv0 = fv_total;
      tick(1'b1, 1'b1, 1'b0);
      chk("nf_err", 32'(bus.sync_err), 32'd1);
      chk("nf_locked", 32'(bus.locked), 32'd0);
      chk("nf_s", 32'(bus.S), 32'd0);
      chk("nf_fv", 32'(bus.frame_valid), 32'd0);
      send_bits(32'hCAFEF00D, 1, 31, 0);
      tick(1'b1, 1'b0, 1'b0);
      chk("nf_still_hunt", 32'(bus.locked), 32'd0);
      send_bits(32'h5A5A1234, 0, 30, 0);
      chk("nf_no_fv", 32'(fv_total - fv0), 32'd0);
      chk("nf_d_hold", bus.D, 32'h0F0F0F0F);
      send_bits(32'h5A5A1234, 31, 31, 0);
      chk("nf_d", bus.D, 32'h5A5A1234);
      chk("nf_fv", 32'(bus.frame_valid), 32'd1);

      send_bits(32'h12345678, 0, 31, 0);
      chk("mr_d_pre", bus.D, 32'h12345678);
      send_bits(32'hFFFFFFFF, 0, 11, 0);
      chk("mr_s_pre", 32'(bus.S), 32'd1);
      fv0 = fv_total;
      rst_n = 1'b0;
      tick(1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      chk("mr_d", bus.D, 32'h0);
      chk("mr_locked", 32'(bus.locked), 32'd0);
      chk("mr_s", 32'(bus.S), 32'd0);
      chk("mr_fv", 32'(bus.frame_valid), 32'd0);
      send_bits(32'hFFFFFFFF, 12, 31, 0);
      tick(1'b0, 1'b0, 1'b0);
      chk("mr_no_fv", 32'(fv_total - fv0), 32'd0);
      chk("mr_d_zero", bus.D, 32'h0);
      chk("fv_err_overlap", 32'(both_total), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
